// File: rtl/pdm_pkg.sv
// Shared constants and types for the PDM-to-PCM receiver.
//   CIC_ORDER     : number of integrator/comb stages
//   WARMUP_FRAMES : decimated results discarded after each enable
//   pdm_state_e   : receiver sequencing state
//   cic_bw()      : CIC register width for a given log2 decimation ratio
package pdm_pkg;

    localparam int CIC_ORDER     = 3;
    localparam int WARMUP_FRAMES = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } pdm_state_e;

    // Integrator growth is CIC_ORDER*log2r bits; one extra bit lets the
    // full-scale result R^3 be represented without aliasing to zero.
    function automatic int cic_bw(input int log2r);
        return CIC_ORDER * log2r + 1;
    endfunction

endpackage

// File: rtl/pdm_decoder_cic.sv
// Third-order CIC decimator (M=1) operating on a 1-bit density stream.
//   clk, rst  : system clock, async active-high reset
//   clr_i     : synchronous clear of every counter, integrator and delay
//   tick_i    : input sample strobe
//   bit_i     : sampled PDM bit (1 -> +1, 0 -> 0)
//   y_o       : comb-chain result, valid while y_valid_o is high
//   y_valid_o : high in the clk of the R-th tick of each frame
module cic_decimator
    import pdm_pkg::*;
#(
    parameter  int LOG2_R = 6,
    localparam int BW     = cic_bw(LOG2_R)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          tick_i,
    input  logic          bit_i,
    output logic [BW-1:0] y_o,
    output logic          y_valid_o
);

    logic [BW-1:0]     integ1_q, integ2_q, integ3_q;
    logic [BW-1:0]     integ1_d, integ2_d, integ3_d;
    logic [BW-1:0]     dly1_q, dly2_q, dly3_q;
    logic [BW-1:0]     comb1, comb2, comb3;
    logic [LOG2_R-1:0] dec_cnt_q;
    logic              dec_last;

    // Integrators are chained on their updated values so the comb sees the
    // current tick's input; all arithmetic wraps modulo 2^BW.
    always_comb begin
        integ1_d = integ1_q + {{(BW-1){1'b0}}, bit_i};
        integ2_d = integ2_q + integ1_d;
        integ3_d = integ3_q + integ2_d;
        comb1    = integ3_d - dly1_q;
        comb2    = comb1 - dly2_q;
        comb3    = comb2 - dly3_q;
    end

    assign dec_last  = tick_i && (dec_cnt_q == '1);
    assign y_o       = comb3;
    assign y_valid_o = dec_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            integ1_q  <= '0;
            integ2_q  <= '0;
            integ3_q  <= '0;
            dly1_q    <= '0;
            dly2_q    <= '0;
            dly3_q    <= '0;
            dec_cnt_q <= '0;
        end else if (clr_i) begin
            integ1_q  <= '0;
            integ2_q  <= '0;
            integ3_q  <= '0;
            dly1_q    <= '0;
            dly2_q    <= '0;
            dly3_q    <= '0;
            dec_cnt_q <= '0;
        end else if (tick_i) begin
            integ1_q  <= integ1_d;
            integ2_q  <= integ2_d;
            integ3_q  <= integ3_d;
            dec_cnt_q <= dec_cnt_q + 1'b1;
            if (dec_last) begin
                dly1_q <= integ3_d;
                dly2_q <= comb1;
                dly3_q <= comb2;
            end
        end
    end

endmodule

// File: rtl/pdm_decoder.sv
// PDM-to-PCM receiver: microphone bit-clock generation, input
// synchronisation, CIC decimation and signed PCM output with warm-up.
//   clk, rst    : system clock, async active-high reset
//   en          : enable; low idles the block and clears filter state
//   pdm_in      : 1-bit density stream, asynchronous to clk
//   pdm_clk_out : generated bit clock (held 0 when DIV=0)
//   pcm_out     : signed W-bit PCM sample
//   pcm_valid   : one-clk strobe, pcm_out updated this cycle
//
// state  | meaning
// IDLE   | en low, everything held cleared
// WARMUP | filter filling, first WARMUP_FRAMES results discarded
// RUN    | every decimated result published
module pdm_decoder
    import pdm_pkg::*;
#(
    parameter int W      = 16,
    parameter int LOG2_R = 6,
    parameter int DIV    = 4,
    parameter int EDGE   = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         pdm_in,
    output logic         pdm_clk_out,
    output logic [W-1:0] pcm_out,
    output logic         pcm_valid
);

    localparam int BW   = cic_bw(LOG2_R);
    localparam int FULL = CIC_ORDER * LOG2_R;
    localparam int SH   = FULL - W;
    localparam int XW   = BW + 1;
    localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0]        DIV_LAST = DW'((DIV > 0) ? DIV - 1 : 0);
    localparam logic signed [XW-1:0] MID      = XW'(64'(1) << (FULL - 1));
    localparam logic signed [XW-1:0] PCM_MAX  = XW'((64'(1) << (W - 1)) - 1);

    logic          sync1_q, sync2_q;
    logic [DW-1:0] div_cnt_q;
    logic          pdm_clk_q;
    logic          toggle, edge_match, tick;

    pdm_state_e    state_q, state_d;
    logic [1:0]    warm_cnt_q, warm_cnt_d;

    logic [BW-1:0]        cic_y;
    logic                 cic_y_valid;
    logic signed [XW-1:0] centred, shifted;
    logic [W-1:0]         pcm_q, pcm_d;
    logic                 pcm_valid_q, pcm_valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pdm_in;
            sync2_q <= sync1_q;
        end
    end

    // A rising toggle happens while the clock is still low, so EDGE=0
    // matches when pdm_clk_q is 0 and EDGE=1 when it is 1.
    assign toggle     = (DIV != 0) && en && (div_cnt_q == DIV_LAST);
    assign edge_match = (EDGE == 0) ? ~pdm_clk_q : pdm_clk_q;
    assign tick       = (DIV == 0) ? en : (toggle & edge_match);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            pdm_clk_q <= 1'b0;
        end else if (!en || DIV == 0) begin
            div_cnt_q <= '0;
            pdm_clk_q <= 1'b0;
        end else if (toggle) begin
            div_cnt_q <= '0;
            pdm_clk_q <= ~pdm_clk_q;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    cic_decimator #(.LOG2_R(LOG2_R)) u_cic (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (~en),
        .tick_i    (tick),
        .bit_i     (sync2_q),
        .y_o       (cic_y),
        .y_valid_o (cic_y_valid)
    );

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        if (!en) begin
            state_d    = IDLE;
            warm_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = WARMUP;
                    warm_cnt_d = '0;
                end
                WARMUP: begin
                    if (cic_y_valid) begin
                        if (warm_cnt_q == 2'(WARMUP_FRAMES - 1)) begin
                            state_d = RUN;
                        end else begin
                            warm_cnt_d = warm_cnt_q + 1'b1;
                        end
                    end
                end
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Recentre the unsigned CIC result around zero and drop the excess
    // gain bits; only full-scale positive input needs clamping.
    always_comb begin
        centred = $signed({1'b0, cic_y}) - MID;
        shifted = centred >>> SH;
        if (shifted > PCM_MAX) begin
            pcm_d = PCM_MAX[W-1:0];
        end else begin
            pcm_d = shifted[W-1:0];
        end
    end

    assign pcm_valid_d = cic_y_valid && (state_q == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            warm_cnt_q  <= '0;
            pcm_q       <= '0;
            pcm_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            pcm_valid_q <= pcm_valid_d;
            if (pcm_valid_d) begin
                pcm_q <= pcm_d;
            end
        end
    end

    assign pdm_clk_out = pdm_clk_q;
    assign pcm_out     = pcm_q;
    assign pcm_valid   = pcm_valid_q;

endmodule

// File: tb/tb_pdm_decoder.sv
// Directed bench for pdm_decoder: three instances (DIV=4/EDGE=0,
// DIV=4/EDGE=1, DIV=0 fed by a first-order sigma-delta DAC model).
module tb_pdm_decoder;

    localparam int M_CONST  = 0;
    localparam int M_ALT    = 1;
    localparam int M_FOLLOW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b, en_c;
    logic        pdm_a, pdm_b, pdm_c;
    logic        pclk_a, pclk_b, pclk_c;
    logic [15:0] pcm_a, pcm_b, pcm_c;
    logic        val_a, val_b, val_c;

    int          total = 0;
    int          bad   = 0;

    int          mode_a, mode_b;
    logic        lvl_a, lvl_b;
    logic        prev_pclk_a, rose_a;
    logic [15:0] dac_pcm, dac_acc;

    always #5 clk = ~clk;

    pdm_decoder #(.W(16), .LOG2_R(6), .DIV(4), .EDGE(0)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .pdm_in(pdm_a),
        .pdm_clk_out(pclk_a), .pcm_out(pcm_a), .pcm_valid(val_a));

    pdm_decoder #(.W(16), .LOG2_R(6), .DIV(4), .EDGE(1)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .pdm_in(pdm_b),
        .pdm_clk_out(pclk_b), .pcm_out(pcm_b), .pcm_valid(val_b));

    pdm_decoder #(.W(16), .LOG2_R(6), .DIV(0), .EDGE(0)) dut_c (
        .clk(clk), .rst(rst), .en(en_c), .pdm_in(pdm_c),
        .pdm_clk_out(pclk_c), .pcm_out(pcm_c), .pcm_valid(val_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and update every stimulus source.
    task automatic step();
        logic [16:0] s;
        @(negedge clk);
        rose_a = pclk_a && !prev_pclk_a;
        case (mode_a)
            M_CONST: pdm_a = lvl_a;
            M_ALT:   if (rose_a) pdm_a = ~pdm_a;
            default: pdm_a = pclk_a;
        endcase
        prev_pclk_a = pclk_a;
        if (mode_b == M_FOLLOW) pdm_b = pclk_b;
        else                    pdm_b = lvl_b;
        s       = {1'b0, dac_acc} + {1'b0, dac_pcm ^ 16'h8000};
        dac_acc = s[15:0];
        pdm_c   = s[16];
    endtask

    function automatic logic val_of(input int which);
        case (which)
            0:       return val_a;
            1:       return val_b;
            default: return val_c;
        endcase
    endfunction

    task automatic wait_valid(input int which, input int limit, output int cycles);
        cycles = 0;
        while (cycles < limit) begin
            step();
            cycles++;
            if (val_of(which)) break;
        end
    endtask

    initial begin
        int cyc, n, guard, t0;
        logic seen;

        rst = 1'b1;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        pdm_a = 1'b0; pdm_b = 1'b0; pdm_c = 1'b0;
        mode_a = M_CONST; mode_b = M_CONST;
        lvl_a = 1'b0; lvl_b = 1'b0;
        prev_pclk_a = 1'b0; rose_a = 1'b0;
        dac_pcm = 16'h4000; dac_acc = 16'h0000;

        // reset state
        step(); step();
        check("rst_pcm", {16'h0, pcm_a}, 32'h0000);
        check("rst_valid", {31'h0, val_a}, 32'h0);
        check("rst_pclk", {31'h0, pclk_a}, 32'h0);
        check("rst_pcm_c", {16'h0, pcm_c}, 32'h0000);
        rst = 1'b0;

        // constant ones, DIV=4
        lvl_a = 1'b1;
        step(); step(); step();
        en_a = 1'b1;
        wait_valid(0, 3000, cyc);
        check("ones_first_latency", cyc, 2044);
        check("ones_first_pcm", {16'h0, pcm_a}, 32'h7FFF);
        wait_valid(0, 600, cyc);
        check("ones_spacing", cyc, 512);
        check("ones_second_pcm", {16'h0, pcm_a}, 32'h7FFF);
        step();
        check("valid_one_clk", {31'h0, val_a}, 32'h0);
        check("pcm_held", {16'h0, pcm_a}, 32'h7FFF);
        guard = 0;
        do begin step(); guard++; end while (!rose_a && guard < 20);
        n = 0;
        do begin step(); n++; end while (!rose_a && n < 40);
        check("pclk_period", n, 8);

        // async reset mid-frame while the bit clock is high
        guard = 0;
        while (pclk_a !== 1'b1 && guard < 20) begin step(); guard++; end
        #2 rst = 1'b1;
        #1;
        check("async_rst_pclk", {31'h0, pclk_a}, 32'h0);
        check("async_rst_pcm", {16'h0, pcm_a}, 32'h0000);
        check("async_rst_valid", {31'h0, val_a}, 32'h0);
        step();
        rst = 1'b0;
        wait_valid(0, 3000, cyc);
        check("post_rst_latency", cyc, 2044);
        check("post_rst_pcm", {16'h0, pcm_a}, 32'h7FFF);

        // constant zeros, then alternating per tick
        en_a = 1'b0;
        lvl_a = 1'b0;
        step(); step(); step(); step();
        en_a = 1'b1;
        wait_valid(0, 3000, cyc);
        check("zeros_latency", cyc, 2044);
        check("zeros_pcm", {16'h0, pcm_a}, 32'h8000);
        mode_a = M_ALT;
        for (int i = 0; i < 4; i++) begin
            wait_valid(0, 600, cyc);
            check("alt_spacing", cyc, 512);
        end
        check("alt_pcm_4th", {16'h0, pcm_a}, 32'h0000);
        wait_valid(0, 600, cyc);
        check("alt_pcm_5th", {16'h0, pcm_a}, 32'h0000);

        // en dropped at tick 30 of a frame for 10 clk
        mode_a = M_CONST;
        lvl_a = 1'b1;
        wait_valid(0, 600, cyc);
        check("pre_drop_spacing", cyc, 512);
        n = 0;
        guard = 0;
        while (n < 30 && guard < 400) begin
            step();
            guard++;
            if (rose_a) n++;
        end
        en_a = 1'b0;
        lvl_a = 1'b0;
        for (int i = 0; i < 10; i++) step();
        en_a = 1'b1;
        wait_valid(0, 3000, cyc);
        check("reenable_latency", cyc, 2044);
        check("reenable_pcm", {16'h0, pcm_a}, 32'h8000);

        // sample-edge selection: data follows the bit clock
        en_a = 1'b0;
        step(); step(); step();
        mode_a = M_FOLLOW;
        mode_b = M_FOLLOW;
        step(); step(); step();
        en_a = 1'b1;
        en_b = 1'b1;
        wait_valid(0, 3000, cyc);
        check("edge0_latency", cyc, 2044);
        check("edge0_pcm", {16'h0, pcm_a}, 32'h8000);
        wait_valid(1, 100, cyc);
        check("edge1_extra_latency", cyc, 4);
        check("edge1_pcm", {16'h0, pcm_b}, 32'h7FFF);

        // DIV=0 loopback from the sigma-delta DAC model
        t0 = 0;
        step();
        en_c = 1'b1;
        wait_valid(2, 400, cyc);
        check("loop_latency", cyc, 256);
        check("loop_pcm_4000", {16'h0, pcm_c}, 32'h4000);
        dac_pcm = 16'hC000;
        for (int i = 0; i < 4; i++) begin
            wait_valid(2, 100, cyc);
            check("loop_spacing", cyc, 64);
        end
        check("loop_pcm_c000", {16'h0, pcm_c}, 32'hC000);
        check("loop_pclk_low", {31'h0, pclk_c}, 32'h0);

        // en falls in the very clk of a decimation tick
        for (int i = 0; i < 63; i++) step();
        en_c = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen = seen | val_c;
            t0++;
        end
        check("en_drop_no_valid", {31'h0, seen}, 32'h0);
        check("en_drop_pcm_held", {16'h0, pcm_c}, 32'hC000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
